// File: rtl/audio_zc_monitor.sv
// Per-channel zero-crossing period/peak monitor with settle-then-lock sequencing and
// saturating error counters. Channels are independent replicas that share only inputs.
//
// state      | meaning
// -----------+----------------------------------------------------------------
// ST_IDLE    | disabled, counters cleared, waiting for enable
// ST_ARM     | enabled, waiting for first neg->pos crossing (partial period dropped)
// ST_SETTLE  | counting SETTLE_XINGS further crossings before checking starts
// ST_MEASURE | locked: each crossing publishes period/peak and checks limits

module audio_zc_channel #(
   parameter int DATA_W       = 16,
   parameter int CNT_W        = 12,
   parameter int ERR_W        = 16,
   parameter int SETTLE_XINGS = 10
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   input  logic                     smpl_vld_i,
   input  logic signed [DATA_W-1:0] sample_i,
   input  logic        [CNT_W-1:0]  min_period_i,
   input  logic        [CNT_W-1:0]  max_period_i,
   input  logic signed [DATA_W-1:0] min_ampl_i,
   input  logic signed [DATA_W-1:0] max_ampl_i,
   input  logic                     clr_err_i,
   output logic        [CNT_W-1:0]  period_o,
   output logic signed [DATA_W-1:0] peak_o,
   output logic                     meas_vld_o,
   output logic                     locked_o,
   output logic        [ERR_W-1:0]  freq_err_o,
   output logic        [ERR_W-1:0]  ampl_err_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SETTLE, ST_MEASURE} state_t;

   localparam int SET_W = (SETTLE_XINGS > 1) ? $clog2(SETTLE_XINGS) : 1;
   localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_XINGS > 0) ? SETTLE_XINGS - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_PRE  = {{(CNT_W-1){1'b1}}, 1'b0};
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   state_t                     state_q, state_d;
   logic        [SET_W-1:0]    settle_q, settle_d;
   logic        [CNT_W-1:0]    cnt_q, cnt_d;
   logic signed [DATA_W-1:0]   peak_q, peak_d;
   logic                       sign_q, sign_d;
   logic        [CNT_W-1:0]    period_q, period_d;
   logic signed [DATA_W-1:0]   peak_out_q, peak_out_d;
   logic                       meas_q, meas_d;
   logic        [ERR_W-1:0]    freq_err_q, ampl_err_q;
   logic                       freq_inc, ampl_inc;
   logic                       sample_ev, xing;

   assign sample_ev = enable_i && smpl_vld_i;
   assign xing      = sample_ev && sign_q && !sample_i[DATA_W-1];

   always_comb begin
      state_d    = state_q;
      settle_d   = settle_q;
      cnt_d      = cnt_q;
      peak_d     = peak_q;
      sign_d     = sign_q;
      period_d   = period_q;
      peak_out_d = peak_out_q;
      meas_d     = 1'b0;
      freq_inc   = 1'b0;
      ampl_inc   = 1'b0;

      if (!enable_i) begin
         state_d  = ST_IDLE;
         settle_d = '0;
         cnt_d    = '0;
         peak_d   = '0;
      end else begin
         if (sample_ev) begin
            sign_d = sample_i[DATA_W-1];
            if (xing) begin
               cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
               peak_d = sample_i;
            end else begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
               if (sample_i > peak_q) peak_d = sample_i;
            end
         end

         case (state_q)
            ST_IDLE: state_d = ST_ARM;
            ST_ARM: begin
               if (xing) begin
                  settle_d = '0;
                  state_d  = (SETTLE_XINGS == 0) ? ST_MEASURE : ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (xing) begin
                  if (settle_q == SET_LAST) state_d = ST_MEASURE;
                  else                      settle_d = settle_q + 1'b1;
               end
            end
            ST_MEASURE: begin
               if (xing) begin
                  meas_d     = 1'b1;
                  period_d   = cnt_q;
                  peak_out_d = peak_q;
                  freq_inc   = (cnt_q < min_period_i) || (cnt_q > max_period_i);
                  ampl_inc   = (peak_q < min_ampl_i) || (peak_q > max_ampl_i);
               end else if (sample_ev && cnt_q == CNT_PRE) begin
                  // counter is about to saturate: no crossing seen, treat as lost lock
                  freq_inc = 1'b1;
                  state_d  = ST_ARM;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         settle_q   <= '0;
         cnt_q      <= '0;
         peak_q     <= '0;
         sign_q     <= 1'b0;
         period_q   <= '0;
         peak_out_q <= '0;
         meas_q     <= 1'b0;
         freq_err_q <= '0;
         ampl_err_q <= '0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         cnt_q      <= cnt_d;
         peak_q     <= peak_d;
         sign_q     <= sign_d;
         period_q   <= period_d;
         peak_out_q <= peak_out_d;
         meas_q     <= meas_d;
         if (clr_err_i) begin
            freq_err_q <= '0;
            ampl_err_q <= '0;
         end else begin
            if (freq_inc && freq_err_q != ERR_MAX) freq_err_q <= freq_err_q + 1'b1;
            if (ampl_inc && ampl_err_q != ERR_MAX) ampl_err_q <= ampl_err_q + 1'b1;
         end
      end
   end

   assign period_o   = period_q;
   assign peak_o     = peak_out_q;
   assign meas_vld_o = meas_q;
   assign locked_o   = (state_q == ST_MEASURE);
   assign freq_err_o = freq_err_q;
   assign ampl_err_o = ampl_err_q;

endmodule

module audio_zc_monitor #(
   parameter int NUM_CH       = 2,
   parameter int DATA_W       = 16,
   parameter int CNT_W        = 12,
   parameter int ERR_W        = 16,
   parameter int SETTLE_XINGS = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     smpl_vld,
   input  logic [NUM_CH*DATA_W-1:0] smpl_data,
   input  logic [CNT_W-1:0]         min_period,
   input  logic [CNT_W-1:0]         max_period,
   input  logic [DATA_W-1:0]        min_ampl,
   input  logic [DATA_W-1:0]        max_ampl,
   input  logic                     clr_err,
   output logic [NUM_CH*CNT_W-1:0]  period_out,
   output logic [NUM_CH*DATA_W-1:0] peak_out,
   output logic [NUM_CH-1:0]        meas_vld,
   output logic [NUM_CH-1:0]        locked,
   output logic [NUM_CH*ERR_W-1:0]  freq_err_cnt,
   output logic [NUM_CH*ERR_W-1:0]  ampl_err_cnt
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      audio_zc_channel #(
         .DATA_W       (DATA_W),
         .CNT_W        (CNT_W),
         .ERR_W        (ERR_W),
         .SETTLE_XINGS (SETTLE_XINGS)
      ) u_ch (
         .clk_i        (clk),
         .rst_i        (rst),
         .enable_i     (enable),
         .smpl_vld_i   (smpl_vld),
         .sample_i     (smpl_data[c*DATA_W +: DATA_W]),
         .min_period_i (min_period),
         .max_period_i (max_period),
         .min_ampl_i   (min_ampl),
         .max_ampl_i   (max_ampl),
         .clr_err_i    (clr_err),
         .period_o     (period_out[c*CNT_W +: CNT_W]),
         .peak_o       (peak_out[c*DATA_W +: DATA_W]),
         .meas_vld_o   (meas_vld[c]),
         .locked_o     (locked[c]),
         .freq_err_o   (freq_err_cnt[c*ERR_W +: ERR_W]),
         .ampl_err_o   (ampl_err_cnt[c*ERR_W +: ERR_W])
      );
   end

endmodule

// File: tb/tb_audio_zc_monitor.sv
// Directed bench for audio_zc_monitor: 2-channel instance for lock/limits/timeout/reset,
// 4-channel ERR_W=4 instance for mixed periods and error-counter saturation.
module tb_audio_zc_monitor;

   logic        clk = 1'b0;
   logic        rst, enable, smpl_vld, clr_err;
   logic [31:0] smpl_data;
   logic [11:0] min_period, max_period;
   logic [15:0] min_ampl, max_ampl;
   logic [23:0] period_out;
   logic [31:0] peak_out;
   logic [1:0]  meas_vld, locked;
   logic [31:0] freq_err_cnt, ampl_err_cnt;

   logic        rst4, en4, vld4, clr4;
   logic [63:0] data4;
   logic [11:0] minp4, maxp4;
   logic [15:0] mina4, maxa4;
   logic [47:0] per4;
   logic [63:0] pk4;
   logic [3:0]  mv4, lk4;
   logic [15:0] fe4, ae4;

   int total = 0;
   int bad   = 0;
   int mc2 [2];
   int mc4 [4];
   logic [1:0] mv2;
   int m0, m1;

   always #5 clk = ~clk;

   audio_zc_monitor dut (
      .clk(clk), .rst(rst), .enable(enable), .smpl_vld(smpl_vld), .smpl_data(smpl_data),
      .min_period(min_period), .max_period(max_period), .min_ampl(min_ampl), .max_ampl(max_ampl),
      .clr_err(clr_err), .period_out(period_out), .peak_out(peak_out), .meas_vld(meas_vld),
      .locked(locked), .freq_err_cnt(freq_err_cnt), .ampl_err_cnt(ampl_err_cnt)
   );

   audio_zc_monitor #(.NUM_CH(4), .ERR_W(4)) dut4 (
      .clk(clk), .rst(rst4), .enable(en4), .smpl_vld(vld4), .smpl_data(data4),
      .min_period(minp4), .max_period(maxp4), .min_ampl(mina4), .max_ampl(maxa4),
      .clr_err(clr4), .period_out(per4), .peak_out(pk4), .meas_vld(mv4),
      .locked(lk4), .freq_err_cnt(fe4), .ampl_err_cnt(ae4)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] sq(input int n, input int p, input int a);
      if ((n % p) < (p / 2)) return 16'(-a);
      else                   return 16'(a);
   endfunction

   task automatic send2(input logic [15:0] s0, input logic [15:0] s1, input logic clr);
      @(negedge clk);
      smpl_vld  = 1'b1;
      smpl_data = {s1, s0};
      clr_err   = clr;
      @(negedge clk);
      smpl_vld = 1'b0;
      clr_err  = 1'b0;
      mv2      = meas_vld;
      for (int c = 0; c < 2; c++) if (mv2[c]) mc2[c]++;
   endtask

   task automatic send4(input int n);
      @(negedge clk);
      vld4  = 1'b1;
      data4 = {sq(n, 96, 1000), sq(n, 64, 1000), sq(n, 48, 1000), sq(n, 32, 1000)};
      @(negedge clk);
      vld4 = 1'b0;
      for (int c = 0; c < 4; c++) if (mv4[c]) mc4[c]++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; enable = 1'b0; smpl_vld = 1'b0; clr_err = 1'b0; smpl_data = '0;
      min_period = 12'd40; max_period = 12'd80; min_ampl = 16'd750; max_ampl = 16'd1250;
      rst4 = 1'b1; en4 = 1'b0; vld4 = 1'b0; clr4 = 1'b0; data4 = '0;
      minp4 = 12'd16; maxp4 = 12'd128; mina4 = 16'd750; maxa4 = 16'd900;
      for (int c = 0; c < 2; c++) mc2[c] = 0;
      for (int c = 0; c < 4; c++) mc4[c] = 0;
      mv2 = '0;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_period", 64'(period_out), 0);
      chk("rst_peak", 64'(peak_out), 0);
      chk("rst_mvld", 64'(meas_vld), 0);
      chk("rst_locked", 64'(locked), 0);
      chk("rst_ferr", 64'(freq_err_cnt), 0);
      chk("rst_aerr", 64'(ampl_err_cnt), 0);

      // lock on a 64-sample, +/-1000 square wave
      rst = 1'b0; enable = 1'b1;
      repeat (2) @(negedge clk);
      for (int n = 0; n <= 671; n++) send2(sq(n, 64, 1000), sq(n, 64, 1000), 1'b0);
      chk("pre_lock", 64'(locked), 0);
      send2(sq(672, 64, 1000), sq(672, 64, 1000), 1'b0);
      chk("lock_11th_xing", 64'(locked), 2'b11);
      for (int n = 673; n <= 735; n++) send2(sq(n, 64, 1000), sq(n, 64, 1000), 1'b0);
      chk("no_meas_before_12th", 64'(mc2[0] + mc2[1]), 0);
      send2(sq(736, 64, 1000), sq(736, 64, 1000), 1'b0);
      chk("meas_latency", 64'(mv2), 2'b11);
      chk("period_ch0", 64'(period_out[11:0]), 64);
      chk("period_ch1", 64'(period_out[23:12]), 64);
      chk("peak_ch0", 64'(peak_out[15:0]), 1000);
      for (int n = 737; n <= 864; n++) send2(sq(n, 64, 1000), sq(n, 64, 1000), 1'b0);
      chk("meas_cnt_ch0", 64'(mc2[0]), 3);
      chk("meas_cnt_ch1", 64'(mc2[1]), 3);
      chk("ferr_clean", 64'(freq_err_cnt), 0);
      chk("aerr_clean", 64'(ampl_err_cnt), 0);

      // ch0 amplitude raised to 2000: one amplitude error per measured crossing
      for (int n = 865; n <= 1184; n++) send2(sq(n, 64, 2000), sq(n, 64, 1000), 1'b0);
      chk("aerr_ch0_hi", 64'(ampl_err_cnt[15:0]), 5);
      chk("aerr_ch1_ok", 64'(ampl_err_cnt[31:16]), 0);
      chk("ferr_hi_amp", 64'(freq_err_cnt), 0);
      chk("peak_ch0_hi", 64'(peak_out[15:0]), 2000);

      // clr_err coincident with an increment wins
      for (int n = 1185; n <= 1247; n++) send2(sq(n, 64, 2000), sq(n, 64, 1000), 1'b0);
      send2(sq(1248, 64, 2000), sq(1248, 64, 1000), 1'b1);
      chk("clr_priority", 64'(ampl_err_cnt[15:0]), 0);
      for (int n = 1249; n <= 1312; n++) send2(sq(n, 64, 2000), sq(n, 64, 1000), 1'b0);
      chk("aerr_after_clr", 64'(ampl_err_cnt[15:0]), 1);

      // ch0 stuck at +500: timeout on the 4095th sample of the open period
      m0 = mc2[0]; m1 = mc2[1];
      for (int k = 1; k <= 4093; k++) send2(16'd500, sq(1312 + k, 64, 1000), 1'b0);
      chk("pre_timeout_ferr", 64'(freq_err_cnt[15:0]), 0);
      chk("pre_timeout_lock", 64'(locked), 2'b11);
      send2(16'd500, sq(1312 + 4094, 64, 1000), 1'b0);
      chk("timeout_ferr", 64'(freq_err_cnt[15:0]), 1);
      chk("timeout_lock", 64'(locked), 2'b10);
      for (int k = 4095; k <= 4104; k++) send2(16'd500, sq(1312 + k, 64, 1000), 1'b0);
      chk("timeout_once", 64'(freq_err_cnt[15:0]), 1);
      chk("timeout_no_mvld", 64'(mc2[0] - m0), 0);
      chk("ch1_meas_alive", 64'(mc2[1] - m1), 64);
      chk("ch1_ferr", 64'(freq_err_cnt[31:16]), 0);
      chk("ch1_period", 64'(period_out[23:12]), 64);

      // reset mid-period, then enable low/high: full relock sequence again
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst2_period", 64'(period_out), 0);
      chk("rst2_peak", 64'(peak_out), 0);
      chk("rst2_locked", 64'(locked), 0);
      chk("rst2_ferr", 64'(freq_err_cnt), 0);
      chk("rst2_aerr", 64'(ampl_err_cnt), 0);
      rst = 1'b0;
      for (int n = 0; n <= 39; n++) send2(sq(n, 64, 1000), sq(n, 64, 1000), 1'b0);
      enable = 1'b0;
      send2(16'hFC18, 16'hFC18, 1'b0);
      send2(16'd1000, 16'd1000, 1'b0);
      chk("dis_locked", 64'(locked), 0);
      chk("dis_period", 64'(period_out), 0);
      enable = 1'b1;
      repeat (2) @(negedge clk);
      m0 = mc2[0] + mc2[1];
      for (int n = 0; n <= 671; n++) send2(sq(n, 64, 1000), sq(n, 64, 1000), 1'b0);
      chk("relock_pre", 64'(locked), 0);
      send2(sq(672, 64, 1000), sq(672, 64, 1000), 1'b0);
      chk("relock", 64'(locked), 2'b11);
      for (int n = 673; n <= 735; n++) send2(sq(n, 64, 1000), sq(n, 64, 1000), 1'b0);
      chk("relock_no_early_meas", 64'(mc2[0] + mc2[1] - m0), 0);
      send2(sq(736, 64, 1000), sq(736, 64, 1000), 1'b0);
      chk("relock_first_meas", 64'(mv2), 2'b11);
      chk("relock_period", 64'(period_out), {12'd64, 12'd64});

      // 4 channels at periods 32/48/64/96, peaks always above window
      rst4 = 1'b0; en4 = 1'b1;
      repeat (2) @(negedge clk);
      for (int n = 0; n < 3360; n++) send4(n);
      chk("ch4_meas0", 64'(mc4[0]), 94);
      chk("ch4_meas1", 64'(mc4[1]), 59);
      chk("ch4_meas2", 64'(mc4[2]), 41);
      chk("ch4_meas3", 64'(mc4[3]), 24);
      chk("ch4_period0", 64'(per4[11:0]), 32);
      chk("ch4_period1", 64'(per4[23:12]), 48);
      chk("ch4_period2", 64'(per4[35:24]), 64);
      chk("ch4_period3", 64'(per4[47:36]), 96);
      chk("ch4_peak3", 64'(pk4[63:48]), 1000);
      chk("ch4_aerr_sat", 64'(ae4), 16'hFFFF);
      chk("ch4_ferr", 64'(fe4), 0);
      chk("ch4_locked", 64'(lk4), 4'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/audio_zc_monitor.md
AUDIO_ZC_MONITOR -- requirements
Module: audio_zc_monitor

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent audio channels monitored.
REQ-002 Parameter DATA_W, default 16: signed sample width per channel.
REQ-003 Parameter CNT_W, default 12: width of the period counter, in samples.
REQ-004 Parameter ERR_W, default 16: width of each error counter.
REQ-005 Parameter SETTLE_XINGS, default 10: crossings ignored for checking after enable.
REQ-006 clk  in  1: single clock; all logic is on its rising edge.
REQ-007 rst  in  1: synchronous, active-high reset.
REQ-008 enable  in  1: run monitor; low forces all channels to IDLE.
REQ-009 smpl_vld  in  1: one-cycle strobe; a new sample frame for all channels is present.
REQ-010 smpl_data  in  NUM_CH*DATA_W: packed signed samples, channel 0 in the LSBs.
REQ-011 min_period, max_period  in  CNT_W each: inclusive legal period window.
REQ-012 min_ampl, max_ampl  in  DATA_W each: signed, inclusive legal peak window.
REQ-013 clr_err  in  1: one-cycle pulse that clears all error counters.
REQ-014 period_out  out  NUM_CH*CNT_W: last completed period per channel.
REQ-015 peak_out  out  NUM_CH*DATA_W: signed peak of the last completed period per channel.
REQ-016 meas_vld  out  NUM_CH: per-channel one-cycle pulse; period_out/peak_out updated.
REQ-017 locked  out  NUM_CH: high while the channel is in MEASURE.
REQ-018 freq_err_cnt, ampl_err_cnt  out  NUM_CH*ERR_W each: per-channel error counts.

Function
REQ-019 Channels shall be fully independent replicated instances; only the inputs are shared.
REQ-020 Each channel shall hold the previous sample's sign bit, updated on every smpl_vld while enabled.
REQ-021 A crossing shall occur on a smpl_vld where the previous sample was negative and the current sample is >= 0 (negative-to-positive only); zero counts as positive.
REQ-022 Period counter: at a crossing, capture the count, then load 1; on other samples, increment, saturating at 2^CNT_W-1.
REQ-023 Peak register: at a crossing, load the current sample; on other samples, take the signed max of the register and the sample.
REQ-024 Channel FSM states: IDLE, ARM, SETTLE, MEASURE.
REQ-025 IDLE -> ARM when enable=1.
REQ-026 ARM -> SETTLE on the first crossing; the partial period before it is discarded.
REQ-027 SETTLE -> MEASURE after SETTLE_XINGS further crossings.
REQ-028 Any state -> IDLE when enable=0; the error counters and the last period_out/peak_out shall hold.
REQ-029 In MEASURE, each crossing shall register period_out=count and peak_out=peak (both before reload) and pulse meas_vld for exactly one cycle; latency is 1 clk after the smpl_vld cycle.
REQ-030 On each MEASURE crossing, freq_err_cnt shall increment by 1 if the period is outside [min_period,max_period].
REQ-031 On each MEASURE crossing, ampl_err_cnt shall increment by 1 if the peak is outside [min_ampl,max_ampl] (signed compare).
REQ-032 Both errors on the same crossing shall increment both counters in that cycle.
REQ-033 Timeout: if the period counter reaches saturation in MEASURE, freq_err_cnt shall increment once, locked shall drop, and the state shall go to ARM; there shall be no meas_vld.
REQ-034 Error counters shall saturate at 2^ERR_W-1 and never wrap.
REQ-035 clr_err shall zero all error counters in the next cycle and has priority over a coincident increment.
REQ-036 A smpl_vld with enable=0 shall be ignored entirely.

Reset
REQ-037 While rst=1, all FSMs shall be IDLE and all outputs, counters, previous-sign and peak registers shall be 0.
REQ-038 rst mid-measurement shall abandon the period; after release the channel restarts from IDLE with no meas_vld for the partial period.

Verification
REQ-039 NUM_CH=2; square wave with period 64 samples, +/-1000; limits 40..80 and 750..1250 -> locked after 11 crossings, period_out=64, peak_out=1000, both error counts remain 0.
REQ-040 Same stimulus at amplitude +/-2000 -> ampl_err_cnt increments by 1 per MEASURE crossing and freq_err_cnt stays 0.
REQ-041 Lock channel 0, then drive constant +500 -> after 4095 samples freq_err_cnt[0]=1 and locked[0]=0; channel 1 is unaffected.
REQ-042 clr_err asserted in the same cycle as an error increment -> the counter reads 0 next cycle; with ERR_W=4 and 20 errors, the count saturates at 15.
REQ-043 rst pulsed mid-period, then enable toggled low/high -> all outputs 0, ARM/SETTLE sequence repeats, first meas_vld only after 11 crossings.
REQ-044 NUM_CH=4, periods 32/48/64/96 -> each period_out matches its channel, and meas_vld pulses are independent.
